// File: rtl/channel_llr_buffer_if.sv
// Handshake and read bus between an LLR producer/decoder (master) and the
// ping-pong channel LLR buffer (slave).
interface channel_llr_buffer_if #(
  parameter int unsigned n = 3,
  parameter int unsigned p = 1,
  parameter int unsigned Q = 6,
  parameter int unsigned W = 2
);
  localparam int unsigned G = 2 ** (p + 1);

  logic             in_valid;
  logic             in_ready;
  logic [W*Q-1:0]   in_llr;
  logic             frame_ready;
  logic             dec_take;
  logic             dec_done;
  logic             rd_en;
  logic [n-p-2:0]   rd_addr;
  logic [G*Q-1:0]   rd_data;
  logic             rd_valid;

  modport master (
    output in_valid, in_llr, dec_take, dec_done, rd_en, rd_addr,
    input  in_ready, frame_ready, rd_data, rd_valid
  );

  modport slave (
    input  in_valid, in_llr, dec_take, dec_done, rd_en, rd_addr,
    output in_ready, frame_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/channel_llr_buffer.sv
// Two-bank ping-pong buffer: frames stream in as W-LLR beats and are handed to
// the decoder in arrival order, which then reads G LLRs per registered access.
module channel_llr_buffer #(
  parameter int unsigned n = 3,
  parameter int unsigned p = 1,
  parameter int unsigned Q = 6,
  parameter int unsigned W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  channel_llr_buffer_if.slave  bus
);
  localparam int unsigned N      = 2 ** n;
  localparam int unsigned G      = 2 ** (p + 1);
  localparam int unsigned B      = N / W;
  localparam int unsigned CntW   = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned FrameW = N * Q;
  localparam int unsigned BeatW  = W * Q;
  localparam int unsigned GrpW   = G * Q;

  localparam logic [1:0] StEmpty   = 2'd0;
  localparam logic [1:0] StLoading = 2'd1;
  localparam logic [1:0] StFull    = 2'd2;
  localparam logic [1:0] StActive  = 2'd3;

  localparam logic [CntW-1:0] LastBeat = CntW'(B - 1);

  logic [1:0]        st_q [2];
  logic [1:0]        st_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              tk_ptr_q, tk_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [FrameW-1:0] bank_q [2];
  logic [FrameW-1:0] bank_d [2];
  logic [GrpW-1:0]   rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic active_any;
  logic active_idx;
  logic accept;
  logic take;
  logic done;

  // At most one bank is ever ACTIVE, since a take requires none to be.
  assign active_any = (st_q[0] == StActive) || (st_q[1] == StActive);
  assign active_idx = (st_q[1] == StActive);

  assign bus.in_ready    = (st_q[wr_ptr_q] == StEmpty) || (st_q[wr_ptr_q] == StLoading);
  assign bus.frame_ready = (st_q[tk_ptr_q] == StFull) && !active_any;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign take   = bus.dec_take && bus.frame_ready;
  assign done   = bus.dec_done && active_any;

  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    tk_ptr_d = tk_ptr_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;

    if (accept) begin
      bank_d[wr_ptr_q][32'(cnt_q) * BeatW +: BeatW] = bus.in_llr;
      if (cnt_q == LastBeat) begin
        st_d[wr_ptr_q] = StFull;
        wr_ptr_d       = ~wr_ptr_q;
        cnt_d          = '0;
      end else begin
        st_d[wr_ptr_q] = StLoading;
        cnt_d          = cnt_q + 1'b1;
      end
    end

    // take and done are mutually exclusive: take needs no ACTIVE bank, done needs one.
    if (take) begin
      st_d[tk_ptr_q] = StActive;
      tk_ptr_d       = ~tk_ptr_q;
    end

    if (done) begin
      st_d[active_idx] = StEmpty;
    end
  end

  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    if (bus.rd_en && active_any) begin
      rd_data_d  = bank_q[active_idx][32'(bus.rd_addr) * GrpW +: GrpW];
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]    <= StEmpty;
      st_q[1]    <= StEmpty;
      wr_ptr_q   <= 1'b0;
      tk_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      wr_ptr_q   <= wr_ptr_d;
      tk_ptr_q   <= tk_ptr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Frame storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end
endmodule

// File: tb/tb_channel_llr_buffer.sv
// Directed bench for channel_llr_buffer at default parameters (N=8, G=4, B=4).
module tb_channel_llr_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  channel_llr_buffer_if bus ();

  channel_llr_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [5:0] lo, input logic [5:0] hi);
    bus.in_valid = 1'b1;
    bus.in_llr   = {hi, lo};
    step();
    bus.in_valid = 1'b0;
  endtask

  // LLR i of the frame carries base+i.
  task automatic load_frame(input logic [5:0] base);
    for (int c = 0; c < 4; c++) begin
      send_beat(base + 6'(2 * c), base + 6'(2 * c + 1));
    end
  endtask

  task automatic cycle(input logic take, input logic dn, input logic rd, input logic addr);
    bus.dec_take = take;
    bus.dec_done = dn;
    bus.rd_en    = rd;
    bus.rd_addr  = addr;
    step();
    bus.dec_take = 1'b0;
    bus.dec_done = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_frame_ready: got %b want 0", bus.frame_ready);
    end
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid);
    end
    checks++;
    if (bus.rd_data !== 24'h0) begin
      failures++;
      $display("FAIL reset_rd_data: got %h want 000000", bus.rd_data);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    send_beat(6'd1, 6'd2);
    send_beat(6'd3, 6'd4);
    send_beat(6'd5, 6'd6);
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready_early: got %b want 0", bus.frame_ready);
    end
    send_beat(6'd7, 6'd8);
    checks++;
    if (bus.frame_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_frame_ready: got %b want 1", bus.frame_ready);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready_after_take: got %b want 0", bus.frame_ready);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== {6'd8, 6'd7, 6'd6, 6'd5}) begin
      failures++;
      $display("FAIL single_read_g1: got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data,
               {6'd8, 6'd7, 6'd6, 6'd5});
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== {6'd4, 6'd3, 6'd2, 6'd1}) begin
      failures++;
      $display("FAIL single_read_g0: got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data,
               {6'd4, 6'd3, 6'd2, 6'd1});
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 24'h0) begin
      failures++;
      $display("FAIL single_read_drop: got v=%b d=%h want v=0 d=000000", bus.rd_valid,
               bus.rd_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      send_beat(6'(10 + 2 * c), 6'(11 + 2 * c));
      if (c == 6) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_ready_beat7: got %b want 1", bus.in_ready);
        end
      end
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_beat8: got %b want 0", bus.in_ready);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_after_take: got in_ready=%b frame_ready=%b want 0 0", bus.in_ready,
               bus.frame_ready);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_after_done: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_ordering();
    do_reset();
    load_frame(6'd10);
    load_frame(6'd30);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.rd_data !== {6'd13, 6'd12, 6'd11, 6'd10}) begin
      failures++;
      $display("FAIL order_read_a: got %h want %h", bus.rd_data, {6'd13, 6'd12, 6'd11, 6'd10});
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.frame_ready !== 1'b1) begin
      failures++;
      $display("FAIL order_ready_after_done: got %b want 1", bus.frame_ready);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== {6'd33, 6'd32, 6'd31, 6'd30}) begin
      failures++;
      $display("FAIL order_read_b0: got v=%b d=%h want v=1 d=%h", bus.rd_valid, bus.rd_data,
               {6'd33, 6'd32, 6'd31, 6'd30});
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.rd_data !== {6'd37, 6'd36, 6'd35, 6'd34}) begin
      failures++;
      $display("FAIL order_read_b1: got %h want %h", bus.rd_data, {6'd37, 6'd36, 6'd35, 6'd34});
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_take_done_same_cycle();
    do_reset();
    load_frame(6'd40);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    send_beat(6'd50, 6'd51);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_parallel_load: got in_ready=%b want 1", bus.in_ready);
    end
    send_beat(6'd52, 6'd53);
    send_beat(6'd54, 6'd55);
    send_beat(6'd56, 6'd57);
    checks++;
    if (bus.frame_ready !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_pre: got frame_ready=%b in_ready=%b want 0 0", bus.frame_ready,
               bus.in_ready);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== {6'd47, 6'd46, 6'd45, 6'd44}) begin
      failures++;
      $display("FAIL simul_read_on_done: got v=%b d=%h want v=1 d=%h", bus.rd_valid,
               bus.rd_data, {6'd47, 6'd46, 6'd45, 6'd44});
    end
    checks++;
    if (bus.frame_ready !== 1'b1 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_post: got frame_ready=%b in_ready=%b want 1 1", bus.frame_ready,
               bus.in_ready);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.rd_data !== {6'd53, 6'd52, 6'd51, 6'd50}) begin
      failures++;
      $display("FAIL simul_read_b: got %h want %h", bus.rd_data, {6'd53, 6'd52, 6'd51, 6'd50});
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_idle_read();
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 24'h0) begin
      failures++;
      $display("FAIL idle_read_empty: got v=%b d=%h want v=0 d=000000", bus.rd_valid,
               bus.rd_data);
    end
    load_frame(6'd1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== {6'd8, 6'd7, 6'd6, 6'd5}) begin
      failures++;
      $display("FAIL idle_read_on_done: got v=%b d=%h want v=1 d=%h", bus.rd_valid,
               bus.rd_data, {6'd8, 6'd7, 6'd6, 6'd5});
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 24'h0) begin
      failures++;
      $display("FAIL idle_read_after_done: got v=%b d=%h want v=0 d=000000", bus.rd_valid,
               bus.rd_data);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send_beat(6'd20, 6'd21);
    send_beat(6'd22, 6'd23);
    do_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_flags: got in_ready=%b frame_ready=%b want 1 0", bus.in_ready,
               bus.frame_ready);
    end
    send_beat(6'd5, 6'd6);
    send_beat(6'd7, 6'd8);
    send_beat(6'd9, 6'd10);
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_ready_early: got %b want 0", bus.frame_ready);
    end
    send_beat(6'd11, 6'd12);
    checks++;
    if (bus.frame_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_frame_ready: got %b want 1", bus.frame_ready);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (bus.rd_data !== {6'd12, 6'd11, 6'd10, 6'd9}) begin
      failures++;
      $display("FAIL midrst_read_g1: got %h want %h", bus.rd_data, {6'd12, 6'd11, 6'd10, 6'd9});
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.rd_data !== {6'd8, 6'd7, 6'd6, 6'd5}) begin
      failures++;
      $display("FAIL midrst_read_g0: got %h want %h", bus.rd_data, {6'd8, 6'd7, 6'd6, 6'd5});
    end
    // Reset while a frame is active must drop it and clear the read register.
    do_reset();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 24'h0) begin
      failures++;
      $display("FAIL actrst_rd: got v=%b d=%h want v=0 d=000000", bus.rd_valid, bus.rd_data);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL actrst_read_dropped: got v=%b want 0", bus.rd_valid);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_llr   = '0;
    bus.dec_take = 1'b0;
    bus.dec_done = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    step();

    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ordering();
    test_take_done_same_cycle();
    test_idle_read();
    test_reset_mid_load();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
